// File: rtl/board_row_streamer.sv
// Streams an atomic snapshot of the game board off-chip, one row per handshake.
// A stalled consumer aborts the frame after ACK_TIMEOUT cycles.
module board_row_streamer #(
  parameter int unsigned ROWS        = 16,
  parameter int unsigned COLS        = 8,
  parameter int unsigned ACK_TIMEOUT = 255,
  localparam int unsigned IW         = $clog2(ROWS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] game_state,
  input  logic                 frame_req,
  input  logic                 row_ack,
  output logic [COLS-1:0]      row_data,
  output logic [IW-1:0]        row_idx,
  output logic                 row_valid,
  output logic                 busy,
  output logic                 frame_done,
  output logic [7:0]           frame_count,
  output logic                 overrun,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [ROWS*COLS-1:0]   r_snap;
  logic [IW-1:0]          r_idx;
  logic [7:0]             r_to_cnt;
  logic                   r_valid;
  logic                   r_busy;
  logic                   r_frame_done;
  logic [7:0]             r_frame_count;
  logic                   r_overrun;
  logic                   r_timeout_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_snap        <= '0;
      r_idx         <= '0;
      r_to_cnt      <= '0;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_req) begin
            r_snap   <= game_state;
            r_idx    <= '0;
            r_to_cnt <= '0;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (frame_req) r_overrun <= 1'b1;
          if (row_ack) begin
            r_to_cnt <= '0;
            if (r_idx == IW'(ROWS - 1)) begin
              r_idx         <= '0;
              r_valid       <= 1'b0;
              r_frame_done  <= 1'b1;
              r_frame_count <= r_frame_count + 8'd1;
              r_state       <= S_DONE;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else if (r_to_cnt == 8'(ACK_TIMEOUT - 1)) begin
            // abandoned frame: no frame_done, frame_count untouched
            r_to_cnt      <= '0;
            r_idx         <= '0;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
        end
        S_DONE: begin
          if (frame_req) r_overrun <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign row_data    = r_snap[COLS*r_idx +: COLS];
  assign row_idx     = r_idx;
  assign row_valid   = r_valid;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_board_row_streamer.sv
// Scoreboard bench for board_row_streamer: expected rows are queued at the
// snapshot edge and popped as each row handshake completes.
module tb_board_row_streamer;

  logic         clock;
  logic         reset;
  logic [127:0] game_state;
  logic         frame_req;
  logic         row_ack;
  logic [7:0]   row_data;
  logic [3:0]   row_idx;
  logic         row_valid;
  logic         busy;
  logic         frame_done;
  logic [7:0]   frame_count;
  logic         overrun;
  logic         timeout_err;

  board_row_streamer #(.ROWS(16), .COLS(8), .ACK_TIMEOUT(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .game_state  (game_state),
    .frame_req   (frame_req),
    .row_ack     (row_ack),
    .row_data    (row_data),
    .row_idx     (row_idx),
    .row_valid   (row_valid),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          checks   = 0;
  int          failures = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  exp_fc;
  logic        exp_over;
  logic        exp_terr;

  localparam logic [127:0] GS_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] GS_B = 128'hA5A5_0F0F_F00F_1234_DEAD_BEEF_CAFE_0001;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_frame(input logic [127:0] gs);
    for (int r = 0; r < 16; r++) exp_q.push_back({4'(r), gs[8*r +: 8]});
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_req = 1'b0; row_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    exp_q.delete();
    exp_fc = 8'd0; exp_over = 1'b0; exp_terr = 1'b0;
    tick();
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (row_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || frame_count !== exp_fc)
      begin
        failures++;
        $display("FAIL %s: valid=%b busy=%b done=%b count=%0d, required 0 0 0 %0d",
                 name, row_valid, busy, frame_done, frame_count, exp_fc);
      end
  endtask

  // One full frame; req_row >= 0 injects frame_req while that row is shown,
  // req_done injects it during the DONE cycle.
  task automatic run_frame(input logic [127:0] gs, input int ack_period, input bit toggle,
                           input int req_row, input bit req_done);
    logic [11:0] cur, prev, expv;
    bit          ack, ack_prev;
    int          acks, cyc;
    game_state = gs; frame_req = 1'b1; row_ack = 1'b0;
    push_frame(gs);
    tick();
    frame_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || row_idx !== 4'd0) begin
      failures++;
      $display("FAIL start: busy=%b idx=%0d, required 1 0", busy, row_idx);
    end
    acks = 0; cyc = 0; ack_prev = 1'b1; prev = '0;
    while (acks < 16 && cyc < 200) begin
      checks++;
      if (row_valid !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL send_flags cyc=%0d: valid=%b done=%b busy=%b, required 1 0 1",
                 cyc, row_valid, frame_done, busy);
      end
      cur = {row_idx, row_data};
      if (!ack_prev) begin
        checks++;
        if (cur !== prev) begin
          failures++;
          $display("FAIL hold cyc=%0d: got %h, required %h", cyc, cur, prev);
        end
      end
      ack = (ack_period <= 1) ? 1'b1 : ((cyc % ack_period) == ack_period - 1);
      row_ack   = ack;
      frame_req = (req_row >= 0 && row_idx == 4'(req_row));
      if (frame_req) exp_over = 1'b1;
      if (toggle) game_state = ~game_state;
      tick();
      frame_req = 1'b0;
      cyc++;
      if (ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL row_extra: got %h, required none", cur);
        end else begin
          expv = exp_q.pop_front();
          if (cur !== expv) begin
            failures++;
            $display("FAIL row: got idx/data %h, required %h", cur, expv);
          end
        end
        acks++;
      end
      prev = cur; ack_prev = ack;
    end
    row_ack = 1'b0;
    checks++;
    if (acks != 16 || cyc != 16 * ack_period) begin
      failures++;
      $display("FAIL frame_len: acks=%0d cycles=%0d, required 16 %0d", acks, cyc, 16 * ack_period);
    end
    exp_fc = exp_fc + 8'd1;
    checks++;
    if (frame_done !== 1'b1 || row_valid !== 1'b0 || busy !== 1'b1 || frame_count !== exp_fc) begin
      failures++;
      $display("FAIL done_cycle: done=%b valid=%b busy=%b count=%0d, required 1 0 1 %0d",
               frame_done, row_valid, busy, frame_count, exp_fc);
    end
    if (req_done) begin
      frame_req = 1'b1;
      exp_over  = 1'b1;
    end
    tick();
    frame_req = 1'b0;
    check_idle("after_done");
    checks++;
    if (overrun !== exp_over || timeout_err !== exp_terr) begin
      failures++;
      $display("FAIL sticky: overrun=%b timeout_err=%b, required %b %b",
               overrun, timeout_err, exp_over, exp_terr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_req = 1'b0; row_ack = 1'b0; game_state = GS_A;
    #3;
    checks++;
    if ({row_data, row_idx, row_valid, busy, frame_done, frame_count, overrun, timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, required 0",
               {row_data, row_idx, row_valid, busy, frame_done, frame_count, overrun, timeout_err});
    end
    do_reset();
    row_ack = 1'b1;
    tick(); tick();
    check_idle("ack_ignored_idle");
    row_ack = 1'b0;
  endtask

  task automatic test_basic();
    run_frame(GS_A, 1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_isolation();
    run_frame(GS_B, 1, 1'b1, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    run_frame(~GS_A, 3, 1'b1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame(GS_B, 1, 1'b0, -1, 1'b0);
    run_frame(GS_A ^ GS_B, 1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_timeout();
    game_state = GS_B; frame_req = 1'b1; row_ack = 1'b0;
    tick();
    frame_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (row_valid !== 1'b1 || timeout_err !== 1'b0 || row_idx !== 4'd0) begin
        failures++;
        $display("FAIL pre_timeout edge=%0d: valid=%b terr=%b idx=%0d, required 1 0 0",
                 k, row_valid, timeout_err, row_idx);
      end
    end
    tick();
    exp_terr = 1'b1;
    check_idle("timeout_abort");
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_err: got %b, required 1", timeout_err);
    end
    row_ack = 1'b1;
    tick(); tick();
    check_idle("idle_after_timeout");
    row_ack = 1'b0;
    run_frame(GS_A, 1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_overrun();
    do_reset();
    run_frame(GS_A, 1, 1'b0, 5, 1'b0);
    tick(); tick();
    check_idle("no_frame_after_row5_req");
    do_reset();
    run_frame(GS_B, 1, 1'b0, -1, 1'b1);
    tick(); tick();
    check_idle("no_frame_after_done_req");
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_done: got %b, required 1", overrun);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    game_state = GS_A; frame_req = 1'b1; row_ack = 1'b1;
    tick();
    frame_req = 1'b0;
    cyc = 0;
    while (row_idx != 4'd7 && cyc < 50) begin
      tick();
      cyc++;
    end
    checks++;
    if (row_idx !== 4'd7 || row_valid !== 1'b1) begin
      failures++;
      $display("FAIL reach_row7: idx=%0d valid=%b, required 7 1", row_idx, row_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({row_data, row_idx, row_valid, busy, frame_done, frame_count, overrun, timeout_err} !== '0) begin
      failures++;
      $display("FAIL async_reset: got %h, required 0",
               {row_data, row_idx, row_valid, busy, frame_done, frame_count, overrun, timeout_err});
    end
    #2 reset = 1'b0;
    exp_q.delete();
    exp_fc = 8'd0; exp_over = 1'b0; exp_terr = 1'b0;
    tick(); tick(); tick();
    check_idle("idle_after_async_reset");
    row_ack = 1'b0;
    run_frame(GS_B, 1, 1'b0, -1, 1'b0);
  endtask

  initial begin
    exp_fc = 8'd0; exp_over = 1'b0; exp_terr = 1'b0;
    test_reset();
    test_basic();
    test_isolation();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_overrun();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
